// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, ALU-pin and response signals around the shared ALU arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             Req0_Valid;
    logic             Req0_Ready;
    logic [OPW-1:0]   Req0_Op;
    logic [WIDTH-1:0] Req0_A;
    logic [WIDTH-1:0] Req0_B;

    logic             Req1_Valid;
    logic             Req1_Ready;
    logic [OPW-1:0]   Req1_Op;
    logic [WIDTH-1:0] Req1_A;
    logic [WIDTH-1:0] Req1_B;

    logic [OPW-1:0]   ALU_Op;
    logic [WIDTH-1:0] ALU_A;
    logic [WIDTH-1:0] ALU_B;
    logic [WIDTH-1:0] ALU_Result;

    logic             Resp_Valid;
    logic             Resp_Id;
    logic [WIDTH-1:0] Resp_Result;
    logic             Resp_Ready;

    modport slave (
        input  Req0_Valid, Req0_Op, Req0_A, Req0_B,
        input  Req1_Valid, Req1_Op, Req1_A, Req1_B,
        input  ALU_Result, Resp_Ready,
        output Req0_Ready, Req1_Ready,
        output ALU_Op, ALU_A, ALU_B,
        output Resp_Valid, Resp_Id, Resp_Result
    );

    modport master (
        output Req0_Valid, Req0_Op, Req0_A, Req0_B,
        output Req1_Valid, Req1_Op, Req1_A, Req1_B,
        output ALU_Result, Resp_Ready,
        input  Req0_Ready, Req1_Ready,
        input  ALU_Op, ALU_A, ALU_B,
        input  Resp_Valid, Resp_Id, Resp_Result
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight at a time: accept -> drive ALU -> hold response until taken.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    alu_share_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             prio_q;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             resp_valid_q;
    logic             resp_id_q;

    logic [1:0]       req_valid;
    logic [1:0]       ready;
    logic             grant_id;
    logic             accept;
    logic [OPW-1:0]   sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    assign req_valid = {bus.Req1_Valid, bus.Req0_Valid};

    // Contention goes to the priority pointer; otherwise the lone valid port wins.
    assign grant_id = (req_valid == 2'b11) ? prio_q : req_valid[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready[gi] = (state_q == IDLE) && !Reset && req_valid[gi]
                               && (grant_id == 1'(gi));
        end
    endgenerate

    assign accept = |ready;
    assign sel_op = grant_id ? bus.Req1_Op : bus.Req0_Op;
    assign sel_a  = grant_id ? bus.Req1_A  : bus.Req0_A;
    assign sel_b  = grant_id ? bus.Req1_B  : bus.Req0_B;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    if (bus.Resp_Ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q      <= sel_op;
                        a_q       <= sel_a;
                        b_q       <= sel_b;
                        resp_id_q <= grant_id;
                    end
                end
                EXEC: begin
                    result_q     <= bus.ALU_Result;
                    resp_valid_q <= 1'b1;
                end
                DONE: begin
                    // The port just served drops to lowest priority.
                    if (bus.Resp_Ready) begin
                        resp_valid_q <= 1'b0;
                        prio_q       <= ~resp_id_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Req0_Ready  = ready[0];
    assign bus.Req1_Ready  = ready[1];
    assign bus.ALU_Op      = op_q;
    assign bus.ALU_A       = a_q;
    assign bus.ALU_B       = b_q;
    assign bus.Resp_Valid  = resp_valid_q;
    assign bus.Resp_Id     = resp_id_q;
    assign bus.Resp_Result = result_q;
endmodule
